// File: rtl/restock_scheduler_pkg.sv
// restock_pkg: shared server states, order-size type and saturating adder
package restock_pkg;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} srv_state_t;
  localparam int FULL_DEF = 50;
  typedef logic [5:0] num_t;
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [6:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {10'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/restock_scheduler_if.sv
// restock_scheduler_if: requester order bus plus per-server completion reports
interface restock_scheduler_if #(parameter int NUM_REQ = 2);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req_valid, req_is_kitch, req_product, req_ready;
  logic [NUM_REQ*6-1:0] req_number;
  logic kitch_done, kitch_product, kitch_busy;
  logic refri_done, refri_product, refri_busy;
  logic [IW-1:0] kitch_id, refri_id;
  restock_pkg::num_t kitch_number, refri_number;
  modport master (
    output req_valid, req_is_kitch, req_product, req_number,
    input req_ready, kitch_done, kitch_id, kitch_product, kitch_number, kitch_busy,
    input refri_done, refri_id, refri_product, refri_number, refri_busy
  );
  modport slave (
    input req_valid, req_is_kitch, req_product, req_number,
    output req_ready, kitch_done, kitch_id, kitch_product, kitch_number, kitch_busy,
    output refri_done, refri_id, refri_product, refri_number, refri_busy
  );
endinterface

// File: rtl/restock_scheduler_server.sv
// restock_server: one supply server; LAT_MODE 0 = rate-based service time, 1 = fixed latency
module restock_server import restock_pkg::*; #(
  parameter bit LAT_MODE = 1'b0,
  parameter int RATE = 5,
  parameter int LAT = 3,
  parameter int FULL = FULL_DEF,
  parameter int IW = 1
) (
  input logic clk,
  input logic rst_n,
  input logic accept,
  input logic [IW-1:0] id_in,
  input logic product_in,
  input num_t number_in,
  output logic idle,
  output logic busy,
  output logic done,
  output logic [IW-1:0] id,
  output logic product,
  output num_t number
);
  localparam int CW = $clog2(FULL + LAT) + 1;
  srv_state_t state, state_nx;
  logic [CW-1:0] cnt, load;
  logic [6:0] n, q;
  logic [IW-1:0] id_q;
  logic prod_q;
  num_t num_q;
  always_comb begin
    n = {1'b0, number_in} > 7'(FULL) ? 7'(FULL) : {1'b0, number_in};
    q = (n + 7'(RATE - 1)) / 7'(RATE);
    load = LAT_MODE ? CW'(LAT) : CW'(q == 7'd0 ? 7'd1 : q);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == S_IDLE ? (accept ? S_BUSY : S_IDLE)
             : state == S_BUSY ? (cnt == CW'(1) ? S_DONE : S_BUSY)
             : S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      id_q <= '0;
      prod_q <= 1'b0;
      num_q <= '0;
    end else if (state == S_IDLE && accept) begin
      cnt <= load;
      id_q <= id_in;
      prod_q <= product_in;
      num_q <= n[5:0];
    end else if (state == S_BUSY) begin
      cnt <= cnt - 1'b1;
    end
  assign idle = state == S_IDLE;
  assign busy = !idle;
  assign done = state == S_DONE;
  assign id = done ? id_q : '0;
  assign product = done ? prod_q : 1'b0;
  assign number = done ? num_q : '0;
endmodule

// File: rtl/restock_scheduler.sv
// restock_scheduler: round-robin sharing of kitchen and refrigerator servers among NUM_REQ requesters
// Defining RESTOCK_STATS_EN adds saturating delivered-item and order totals.
module restock_scheduler import restock_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int KITCH_RATE = 5,
  parameter int REFRI_LAT = 3,
  parameter int FULL = FULL_DEF
) (
  input logic clk,
  input logic rst_n,
  restock_scheduler_if.slave bus
`ifdef RESTOCK_STATS_EN
  ,
  output logic [15:0] kitch_items_total,
  output logic [15:0] refri_items_total,
  output logic [15:0] orders_total
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  num_t nums [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_num
    assign nums[i] = bus.req_number[6*i +: 6];
  end
  for (genvar s = 0; s < 2; s++) begin : g_srv
    logic [NUM_REQ-1:0] mask, ready;
    logic [IW-1:0] ptr, win, cand, id;
    logic found, accept, idle, busy, done, product;
    num_t number;
    assign mask = bus.req_valid & (s == 0 ? bus.req_is_kitch : ~bus.req_is_kitch);
    // scanning downward lets the candidate nearest the pointer win
    always_comb begin
      found = 1'b0;
      win = '0;
      cand = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
        cand = IW'((int'(ptr) + j) % NUM_REQ);
        if (mask[cand]) begin
          found = 1'b1;
          win = cand;
        end
      end
    end
    assign accept = idle & found;
    assign ready = accept ? {{(NUM_REQ-1){1'b0}}, 1'b1} << win : '0;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr <= '0;
      else if (accept) ptr <= win == IW'(NUM_REQ - 1) ? '0 : win + 1'b1;
    restock_server #(
      .LAT_MODE(s == 1),
      .RATE(KITCH_RATE),
      .LAT(REFRI_LAT),
      .FULL(FULL),
      .IW(IW)
    ) u_srv (
      .clk(clk),
      .rst_n(rst_n),
      .accept(accept),
      .id_in(win),
      .product_in(bus.req_product[win]),
      .number_in(nums[win]),
      .idle(idle),
      .busy(busy),
      .done(done),
      .id(id),
      .product(product),
      .number(number)
    );
  end
  assign bus.req_ready = g_srv[0].ready | g_srv[1].ready;
  assign bus.kitch_done = g_srv[0].done;
  assign bus.kitch_id = g_srv[0].id;
  assign bus.kitch_product = g_srv[0].product;
  assign bus.kitch_number = g_srv[0].number;
  assign bus.kitch_busy = g_srv[0].busy;
  assign bus.refri_done = g_srv[1].done;
  assign bus.refri_id = g_srv[1].id;
  assign bus.refri_product = g_srv[1].product;
  assign bus.refri_number = g_srv[1].number;
  assign bus.refri_busy = g_srv[1].busy;
`ifdef RESTOCK_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      kitch_items_total <= '0;
      refri_items_total <= '0;
      orders_total <= '0;
    end else begin
      kitch_items_total <= sat_add16(kitch_items_total, {1'b0, bus.kitch_number});
      refri_items_total <= sat_add16(refri_items_total, {1'b0, bus.refri_number});
      orders_total <= sat_add16(orders_total, 7'(bus.kitch_done) + 7'(bus.refri_done));
    end
`endif
endmodule

// File: tb/tb_restock_scheduler.sv
// tb_restock_scheduler: directed and randomized checks of restock_scheduler against a service-timeline model
module tb_restock_scheduler;
  localparam int N = 2, RATE = 5, RLAT = 3, FULLV = 50;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  restock_scheduler_if #(.NUM_REQ(N)) bus ();
`ifdef RESTOCK_STATS_EN
  logic [15:0] kitch_items_total, refri_items_total, orders_total;
`endif
  restock_scheduler #(.NUM_REQ(N), .KITCH_RATE(RATE), .REFRI_LAT(RLAT), .FULL(FULLV)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef RESTOCK_STATS_EN
    ,
    .kitch_items_total(kitch_items_total),
    .refri_items_total(refri_items_total),
    .orders_total(orders_total)
`endif
  );
  int checks = 0, errors = 0, cyc = 0;
  bit chk_en = 1'b0;
  bit ord_v [N];
  bit ord_k [N];
  bit ord_p [N];
  int ord_n [N];
  // model: per server the accept cycle, done cycle, latched report and pointer
  int m_ptr [2], m_acc [2], m_done [2], m_id [2], m_prod [2], m_num [2];
  int m_tot [3];
  bit [N-1:0] e_ready;
  bit e_done [2], e_busy [2];
  int e_id [2], e_prod [2], e_num [2], e_tot [3];
  int k_cnt = 0, r_cnt = 0, k_cyc = 0, r_cyc = 0, k_id = 0, r_id = 0, k_num = 0, r_num = 0;
  int acc_cyc [N];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int svc(input int s, input int n);
    return s == 1 ? RLAT : (n == 0 ? 1 : (n + RATE - 1) / RATE);
  endfunction

  function automatic int sat(input int x);
    return x > 65535 ? 65535 : x;
  endfunction

  always @(negedge clk) if (chk_en) begin
    check("req_ready", int'(bus.req_ready), int'(e_ready));
    check("kitch_done", int'(bus.kitch_done), int'(e_done[0]));
    check("kitch_busy", int'(bus.kitch_busy), int'(e_busy[0]));
    check("kitch_id", int'(bus.kitch_id), e_id[0]);
    check("kitch_product", int'(bus.kitch_product), e_prod[0]);
    check("kitch_number", int'(bus.kitch_number), e_num[0]);
    check("refri_done", int'(bus.refri_done), int'(e_done[1]));
    check("refri_busy", int'(bus.refri_busy), int'(e_busy[1]));
    check("refri_id", int'(bus.refri_id), e_id[1]);
    check("refri_product", int'(bus.refri_product), e_prod[1]);
    check("refri_number", int'(bus.refri_number), e_num[1]);
`ifdef RESTOCK_STATS_EN
    check("kitch_items_total", int'(kitch_items_total), e_tot[0]);
    check("refri_items_total", int'(refri_items_total), e_tot[1]);
    check("orders_total", int'(orders_total), e_tot[2]);
`endif
    if (bus.kitch_done) begin
      k_cnt++;
      k_cyc = cyc;
      k_id = int'(bus.kitch_id);
      k_num = int'(bus.kitch_number);
    end
    if (bus.refri_done) begin
      r_cnt++;
      r_cyc = cyc;
      r_id = int'(bus.refri_id);
      r_num = int'(bus.refri_number);
    end
    for (int i = 0; i < N; i++) if (bus.req_valid[i] && bus.req_ready[i]) acc_cyc[i] = cyc;
  end

  task automatic step();
    bit taken;
    int g;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = ord_v[i];
      bus.req_is_kitch[i] = ord_k[i];
      bus.req_product[i] = ord_p[i];
      bus.req_number[6*i +: 6] = 6'(ord_n[i]);
    end
    e_ready = '0;
    for (int t = 0; t < 3; t++) e_tot[t] = m_tot[t];
    for (int s = 0; s < 2; s++) begin
      e_done[s] = cyc == m_done[s];
      e_busy[s] = cyc > m_acc[s] && cyc <= m_done[s];
      e_id[s] = e_done[s] ? m_id[s] : 0;
      e_prod[s] = e_done[s] ? m_prod[s] : 0;
      e_num[s] = e_done[s] ? m_num[s] : 0;
      if (e_done[s]) begin
        m_tot[s] = sat(m_tot[s] + m_num[s]);
        m_tot[2] = sat(m_tot[2] + 1);
      end
      taken = 1'b0;
      if (rst_n && cyc > m_done[s])
        for (int j = 0; j < N; j++) begin
          g = (m_ptr[s] + j) % N;
          if (!taken && ord_v[g] && ord_k[g] == (s == 0)) begin
            taken = 1'b1;
            e_ready[g] = 1'b1;
            m_acc[s] = cyc;
            m_num[s] = ord_n[g] > FULLV ? FULLV : ord_n[g];
            m_done[s] = cyc + svc(s, m_num[s]) + 1;
            m_id[s] = g;
            m_prod[s] = int'(ord_p[g]);
            m_ptr[s] = (g + 1) % N;
            ord_v[g] = 1'b0;
          end
        end
    end
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic put(input int i, input bit k, input int n);
    ord_v[i] = 1'b1;
    ord_k[i] = k;
    ord_p[i] = 1'($urandom);
    ord_n[i] = n;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) ord_v[i] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      m_ptr[s] = 0;
      m_acc[s] = -100;
      m_done[s] = -100;
    end
    for (int t = 0; t < 3; t++) m_tot[t] = 0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int srv, input int bound);
    int n0;
    int t;
    n0 = srv == 0 ? k_cnt : r_cnt;
    t = 0;
    while ((srv == 0 ? k_cnt : r_cnt) == n0 && t < bound) begin
      step();
      t++;
    end
    if ((srv == 0 ? k_cnt : r_cnt) == n0) check("done_within_bound", t, -1);
  endtask

  initial begin
    int c0, c1, n0;
    for (int i = 0; i < N; i++) begin
      ord_v[i] = 1'b0;
      ord_k[i] = 1'b0;
      ord_p[i] = 1'b0;
      ord_n[i] = 0;
      acc_cyc[i] = -1;
    end
    bus.req_valid = '0;
    bus.req_is_kitch = '0;
    bus.req_product = '0;
    bus.req_number = '0;
    @(posedge clk);
    #1;
    do_reset();
    // single kitchen order of 12: ceil(12/5)=3 -> done 4 cycles after accept
    c0 = cyc;
    put(0, 1'b1, 12);
    wait_done(0, 20);
    check("t1_accept_cycle", acc_cyc[0], c0);
    check("t1_latency", k_cyc - c0, 4);
    check("t1_id", k_id, 0);
    check("t1_number", k_num, 12);
    // contention and pointer rotation, one-cycle service each
    do_reset();
    c0 = cyc;
    put(0, 1'b1, 5);
    put(1, 1'b1, 5);
    step();
    put(0, 1'b1, 5);
    repeat (8) step();
    check("t2_req1_accept", acc_cyc[1], c0 + 3);
    check("t2_req0_second_accept", acc_cyc[0], c0 + 6);
    // both servers in parallel
    do_reset();
    c0 = cyc;
    put(0, 1'b1, 5);
    put(1, 1'b0, 20);
    repeat (6) step();
    check("t3_k_accept", acc_cyc[0], c0);
    check("t3_r_accept", acc_cyc[1], c0);
    check("t3_k_latency", k_cyc - c0, 2);
    check("t3_r_latency", r_cyc - c0, 4);
    check("t3_k_id", k_id, 0);
    check("t3_r_id", r_id, 1);
    check("t3_r_number", r_num, 20);
    // clamp then zero-size order
    do_reset();
    c0 = cyc;
    put(0, 1'b1, 60);
    wait_done(0, 20);
    check("t4_clamp_latency", k_cyc - c0, 11);
    check("t4_clamp_number", k_num, 50);
    c1 = cyc;
    put(0, 1'b1, 0);
    wait_done(0, 20);
    check("t4_zero_latency", k_cyc - c1, 2);
    check("t4_zero_number", k_num, 0);
    // reset mid-service
    do_reset();
    put(0, 1'b1, 40);
    repeat (4) step();
    n0 = k_cnt;
    do_reset();
    repeat (12) step();
    check("t5_no_done_after_reset", k_cnt - n0, 0);
    c1 = cyc;
    put(1, 1'b1, 12);
    wait_done(0, 20);
    check("t5_latency", k_cyc - c1, 4);
    check("t5_id", k_id, 1);
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++)
        if (!ord_v[i] && $urandom_range(0, 2) == 0) put(i, 1'($urandom), int'($urandom_range(0, 63)));
      if ($urandom_range(0, 999) == 0) do_reset();
      else step();
    end
`ifdef RESTOCK_STATS_EN
    do_reset();
    put(0, 1'b1, 12);
    wait_done(0, 20);
    put(0, 1'b1, 50);
    wait_done(0, 20);
    check("t6_kitch_total", int'(kitch_items_total), 62);
    check("t6_orders_total", int'(orders_total), 2);
    for (int k = 0; k < 1320; k++) begin
      put(0, 1'b1, 50);
      wait_done(0, 20);
    end
    check("t6_kitch_saturated", int'(kitch_items_total), 65535);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/restock_scheduler.md
Name: restock_scheduler

Overview:
- Shares the two supply resources (kitchen, refrigerator) among NUM_REQ store controllers that issue restock orders.
- Each resource serves one order at a time. Requesters are arbitrated per resource with round-robin.
- Each server runs its own service timer and pulses a completion report tagged with the requester id.
- The block sits between the store controllers and the supply side. It replaces direct point-to-point valid/ready links.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- KITCH_RATE, 5, items the kitchen produces per cycle.
- REFRI_LAT, 3, fixed refrigerator service cycles per order (>=1).
- FULL, 50, maximum order size; larger orders are clamped.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  order pending, one bit per requester
- req_is_kitch  in  NUM_REQ  1 = kitchen order, 0 = refrigerator order
- req_product  in  NUM_REQ  product address within the resource
- req_number  in  NUM_REQ*6  item count, requester i at bits [6i+5:6i]
- req_ready  out  NUM_REQ  order accepted this cycle
- kitch_done  out  1  one-cycle kitchen completion pulse
- kitch_id  out  $clog2(NUM_REQ)  requester served by kitchen
- kitch_product  out  1  product delivered by kitchen
- kitch_number  out  6  items delivered by kitchen (after clamp)
- refri_done, refri_id, refri_product, refri_number  out  same as kitchen  refrigerator completion
- kitch_busy, refri_busy  out  1  server not IDLE

Behaviour:
- Reset: all outputs 0, both servers IDLE, both round-robin pointers 0. rst_n low mid-service aborts the order with no done pulse.
- Handshake:
  - req_ready[i] is combinational: its server is IDLE and requester i is that server's arbitration winner.
  - Transfer when req_valid[i] && req_ready[i]. Requesters hold all fields stable until accepted.
  - At most one requester is granted per server per cycle. Kitchen and refrigerator may each accept one order in the same cycle.
- Arbitration:
  - Per server, search from pointer p upward (modulo NUM_REQ) over requesters with valid set and matching req_is_kitch.
  - After a grant to requester g, p <= (g+1) mod NUM_REQ.
- Server FSM, per server: IDLE -> BUSY -> DONE -> IDLE.
  - IDLE: on accept, latch id/product/number and load the counter. Next state BUSY.
  - Number clamp: n = min(req_number, FULL).
  - Kitchen counter = max(1, ceil(n/KITCH_RATE)); refrigerator counter = REFRI_LAT.
  - BUSY: decrement each cycle. When counter == 1, go to DONE.
  - DONE: done pulse high with latched id/product/number. No accept this cycle; return to IDLE.
  - Latency from the accept edge to the done cycle = counter + 1. A new accept is possible the cycle after DONE.
- Number 0 is a legal order: 1 BUSY cycle, reported number 0.
- *_id/*_product/*_number are 0 whenever the matching done is low.
- Arithmetic: ceil via (n + KITCH_RATE - 1) / KITCH_RATE on 7 bits. Counter width $clog2(FULL+REFRI_LAT)+1.

Optional Feature:
- Macro RESTOCK_STATS_EN.
- Defined:
  - Adds outputs kitch_items_total and refri_items_total (16 bit each) and orders_total (16 bit).
  - Each counter is incremented on the matching done pulse by the delivered number, or by 1 for orders_total.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package restock_pkg holds:
  - typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} srv_state_t;
  - localparam FULL_DEF = 50;
  - typedef logic [5:0] num_t.
- Sub-module restock_server: FSM, counter and output latch, instantiated twice with a LAT_MODE parameter (rate vs fixed).
- Round-robin arbitration stays in the top.

Test Plan:
1. Single kitchen order: req0 valid, kitch, number 12 -> ready0 in the same cycle; kitch_done 4 cycles after the accept edge with id 0, number 12; kitch_busy high for those cycles.
2. Contention: req0 and req1 both kitchen from reset -> req0 granted first; req1 granted the cycle after kitch_done. Repeat both -> req0 granted after req1 completes (pointer rotation verified).
3. Parallel servers: req0 kitchen number 5, req1 refrigerator number 20 in the same cycle -> both ready; kitch_done at +2 and refri_done at +4, correct ids.
4. Clamp and zero: kitchen number 60 -> kitch_number 50, done at +11. Then number 0 -> done at +2, number 0.
5. Reset during BUSY: assert rst_n low mid-order -> no done, all outputs 0, next order after release is served normally.
6. With RESTOCK_STATS_EN: orders of 12 and 50 to the kitchen -> kitch_items_total = 62, orders_total = 2. Force near-saturation -> holds at FFFF.
